// File: rtl/picomem_arbiter_2to1.sv
// Two-master to one-slave PicoMem arbiter with a registered grant, round-robin or
// fixed-priority tie breaking, and a watchdog that completes hung accesses with an error word.
module picomem_arbiter_2to1 #(
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int          TIMEOUT    = 8,
   parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_m0_valid,
   input  logic [31:0] mem_m0_addr,
   input  logic [31:0] mem_m0_wdata,
   input  logic [3:0]  mem_m0_wstrb,
   output logic        mem_m0_ready,
   output logic [31:0] mem_m0_rdata,
   input  logic        mem_m1_valid,
   input  logic [31:0] mem_m1_addr,
   input  logic [31:0] mem_m1_wdata,
   input  logic [3:0]  mem_m1_wstrb,
   output logic        mem_m1_ready,
   output logic [31:0] mem_m1_rdata,
   output logic        mem_s_valid,
   output logic [31:0] mem_s_addr,
   output logic [31:0] mem_s_wdata,
   output logic [3:0]  mem_s_wstrb,
   input  logic        mem_s_ready,
   input  logic [31:0] mem_s_rdata,
   input  logic        err_clr,
   output logic        timeout_err,
   output logic [1:0]  dbg_state
);

   // Handshake: a master holds valid with addr/wdata/wstrb stable until its ready pulses for
   // exactly one cycle; the slave side sees the same contract, and ready is only forwarded
   // to the master that currently owns the grant.

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               last_grant;
   logic [CNT_W-1:0]   count;
   logic               busy;
   logic               timeout_hit;

   assign busy = (state != IDLE);

   always_comb begin
      timeout_hit = 1'b0;
      if (TIMEOUT > 0)
         timeout_hit = busy && !mem_s_ready && (count == CNT_W'(TIMEOUT - 1));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // last_grant==1 means master 0 is next in line on a tie
            if (mem_m0_valid && mem_m1_valid)
               state_nxt = (FIXED_PRIO || last_grant) ? BUSY0 : BUSY1;
            else if (mem_m0_valid)
               state_nxt = BUSY0;
            else if (mem_m1_valid)
               state_nxt = BUSY1;
         end
         BUSY0, BUSY1: begin
            if (mem_s_ready || timeout_hit)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         count       <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt != IDLE) begin
            last_grant <= (state_nxt == BUSY1);
            count      <= '0;
         end else if (busy && !mem_s_ready && count != '1) begin
            count <= count + 1'b1;
         end
         // a timeout in the same cycle as err_clr keeps the flag set
         if (timeout_hit)
            timeout_err <= 1'b1;
         else if (err_clr)
            timeout_err <= 1'b0;
      end
   end

   assign mem_s_addr  = (state == BUSY1) ? mem_m1_addr  : mem_m0_addr;
   assign mem_s_wdata = (state == BUSY1) ? mem_m1_wdata : mem_m0_wdata;
   assign mem_s_wstrb = (state == BUSY1) ? mem_m1_wstrb : mem_m0_wstrb;
   assign mem_s_valid = ((state == BUSY0 && mem_m0_valid) ||
                         (state == BUSY1 && mem_m1_valid)) && !timeout_hit;

   assign mem_m0_ready = (state == BUSY0) && (mem_s_ready || timeout_hit);
   assign mem_m1_ready = (state == BUSY1) && (mem_s_ready || timeout_hit);
   assign mem_m0_rdata = (state == BUSY0 && timeout_hit) ? ERR_RDATA : mem_s_rdata;
   assign mem_m1_rdata = (state == BUSY1 && timeout_hit) ? ERR_RDATA : mem_s_rdata;

   assign dbg_state = state;

endmodule

// File: tb/tb_picomem_arbiter_2to1.sv
// Directed bench for picomem_arbiter_2to1: a round-robin DUT with a small memory slave model
// and a fixed-priority DUT sharing the same masters for the starvation case.
module tb_picomem_arbiter_2to1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BUSY0 = 2'd1;
   localparam logic [1:0] S_BUSY1 = 2'd2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        err_clr = 1'b0;
   logic        timeout_err;
   logic [1:0]  dbg_state;

   logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_timeout_err;
   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
   logic [3:0]  fp_s_wstrb;
   logic [1:0]  fp_dbg_state;
   logic        fp_s_ready;

   logic        slave_auto = 1'b1;
   logic        man_ready = 1'b0;
   logic [31:0] man_rdata = '0;
   logic        auto_ready;
   logic [31:0] auto_rdata;
   logic [31:0] mem [0:63];

   int n_checks = 0;
   int n_fail = 0;
   logic [0:0] exp_q[$];
   logic [0:0] got_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   picomem_arbiter_2to1 #(.FIXED_PRIO(1'b0), .TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)) dut (
      .clk(clk), .resetn(resetn),
      .mem_m0_valid(m0_valid), .mem_m0_addr(m0_addr), .mem_m0_wdata(m0_wdata),
      .mem_m0_wstrb(m0_wstrb), .mem_m0_ready(m0_ready), .mem_m0_rdata(m0_rdata),
      .mem_m1_valid(m1_valid), .mem_m1_addr(m1_addr), .mem_m1_wdata(m1_wdata),
      .mem_m1_wstrb(m1_wstrb), .mem_m1_ready(m1_ready), .mem_m1_rdata(m1_rdata),
      .mem_s_valid(s_valid), .mem_s_addr(s_addr), .mem_s_wdata(s_wdata),
      .mem_s_wstrb(s_wstrb), .mem_s_ready(s_ready), .mem_s_rdata(s_rdata),
      .err_clr(err_clr), .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   picomem_arbiter_2to1 #(.FIXED_PRIO(1'b1), .TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)) dut_fp (
      .clk(clk), .resetn(resetn),
      .mem_m0_valid(m0_valid), .mem_m0_addr(m0_addr), .mem_m0_wdata(m0_wdata),
      .mem_m0_wstrb(m0_wstrb), .mem_m0_ready(fp_m0_ready), .mem_m0_rdata(fp_m0_rdata),
      .mem_m1_valid(m1_valid), .mem_m1_addr(m1_addr), .mem_m1_wdata(m1_wdata),
      .mem_m1_wstrb(m1_wstrb), .mem_m1_ready(fp_m1_ready), .mem_m1_rdata(fp_m1_rdata),
      .mem_s_valid(fp_s_valid), .mem_s_addr(fp_s_addr), .mem_s_wdata(fp_s_wdata),
      .mem_s_wstrb(fp_s_wstrb), .mem_s_ready(fp_s_ready), .mem_s_rdata(32'h0F0F0F0F),
      .err_clr(1'b0), .timeout_err(fp_timeout_err), .dbg_state(fp_dbg_state)
   );

   // ---------------- slave models (ready one cycle after valid) ----------------
   assign s_ready = slave_auto ? auto_ready : man_ready;
   assign s_rdata = slave_auto ? auto_rdata : man_rdata;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         auto_ready <= 1'b0;
         auto_rdata <= '0;
         mem[4]     <= 32'h12345678;
      end else if (s_valid && !auto_ready) begin
         auto_ready <= 1'b1;
         auto_rdata <= mem[s_addr[7:2]];
         for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end else begin
         auto_ready <= 1'b0;
      end
   end

   always @(posedge clk or negedge resetn) begin
      if (!resetn) fp_s_ready <= 1'b0;
      else         fp_s_ready <= fp_s_valid && !fp_s_ready;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_masters();
      m0_valid = 1'b0; m1_valid = 1'b0;
      m0_wstrb = '0;   m1_wstrb = '0;
   endtask

   task automatic do_reset();
      idle_masters();
      man_ready = 1'b0;
      err_clr   = 1'b0;
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn = 1'b0;
      #3;
      n_checks++;
      if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
      n_checks++;
      if ({s_valid, m0_ready, m1_ready, timeout_err} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {s_valid, m0_ready, m1_ready, timeout_err});
      end
      do_reset();
   endtask

   task automatic test_single_read();
      do_reset();
      slave_auto = 1'b1;
      m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
      #1;
      n_checks++;
      if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rd_c0_svalid: got %b expected 0", s_valid); end
      tick();
      n_checks++;
      if (s_valid !== 1'b1 || dbg_state !== S_BUSY0 || s_addr !== 32'h10) begin
         n_fail++; $display("FAIL rd_c1: got valid=%b state=%0d addr=%h expected 1 1 00000010", s_valid, dbg_state, s_addr);
      end
      tick();
      n_checks++;
      if (m0_ready !== 1'b1 || m0_rdata !== 32'h12345678 || m1_ready !== 1'b0) begin
         n_fail++; $display("FAIL rd_c2: got m0_ready=%b rdata=%h m1_ready=%b expected 1 12345678 0", m0_ready, m0_rdata, m1_ready);
      end
      tick();
      m0_valid = 1'b0;
      n_checks++;
      if (dbg_state !== S_IDLE || m0_ready !== 1'b0) begin
         n_fail++; $display("FAIL rd_c3: got state=%0d m0_ready=%b expected 0 0", dbg_state, m0_ready);
      end
   endtask

   task automatic test_both_write_read();
      do_reset();
      slave_auto = 1'b1;
      m0_valid = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hA5A5A5A5; m0_wstrb = 4'hF;
      m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h0;        m1_wstrb = 4'h0;
      tick();
      n_checks++;
      if (dbg_state !== S_BUSY0 || s_wstrb !== 4'hF || s_wdata !== 32'hA5A5A5A5) begin
         n_fail++; $display("FAIL wr_c1: got state=%0d wstrb=%h wdata=%h expected 1 f a5a5a5a5", dbg_state, s_wstrb, s_wdata);
      end
      tick();
      n_checks++;
      if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
         n_fail++; $display("FAIL wr_c2: got m0_ready=%b m1_ready=%b expected 1 0", m0_ready, m1_ready);
      end
      tick();
      m0_valid = 1'b0; m0_wstrb = 4'h0;
      n_checks++;
      if (dbg_state !== S_IDLE || s_valid !== 1'b0) begin
         n_fail++; $display("FAIL wr_c3: got state=%0d s_valid=%b expected 0 0", dbg_state, s_valid);
      end
      tick();
      n_checks++;
      if (dbg_state !== S_BUSY1 || s_addr !== 32'h20 || s_wstrb !== 4'h0 || m1_ready !== 1'b0) begin
         n_fail++; $display("FAIL rd_m1_c4: got state=%0d addr=%h wstrb=%h m1_ready=%b expected 2 00000020 0 0", dbg_state, s_addr, s_wstrb, m1_ready);
      end
      tick();
      n_checks++;
      if (m1_ready !== 1'b1 || m1_rdata !== 32'hA5A5A5A5 || m0_ready !== 1'b0) begin
         n_fail++; $display("FAIL rd_m1_c5: got m1_ready=%b rdata=%h m0_ready=%b expected 1 a5a5a5a5 0", m1_ready, m1_rdata, m0_ready);
      end
      tick();
      m1_valid = 1'b0;
   endtask

   task automatic test_round_robin();
      int fp_m0_cnt;
      int fp_m1_cnt;
      fp_m0_cnt = 0;
      fp_m1_cnt = 0;
      do_reset();
      slave_auto = 1'b1;
      exp_q.delete(); got_q.delete();
      exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      m0_valid = 1'b1; m0_addr = 32'h10;
      m1_valid = 1'b1; m1_addr = 32'h10;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (m0_ready) got_q.push_back(1'b0);
         if (m1_ready) got_q.push_back(1'b1);
         if (fp_m0_ready) fp_m0_cnt++;
         if (fp_m1_ready) fp_m1_cnt++;
      end
      idle_masters();
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rr_grant_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [0:0] e, g;
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL rr_grant_order: got master %0d expected master %0d", g, e); end
      end
      n_checks++;
      if (fp_m0_cnt != 4 || fp_m1_cnt != 0) begin
         n_fail++; $display("FAIL fp_starve: got m0=%0d m1=%0d grants expected 4 0", fp_m0_cnt, fp_m1_cnt);
      end
      n_checks++;
      if (fp_timeout_err !== 1'b0 || fp_s_addr !== 32'h10) begin
         n_fail++; $display("FAIL fp_misc: got err=%b addr=%h expected 0 00000010", fp_timeout_err, fp_s_addr);
      end
      repeat (2) tick();
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      do_reset();
      slave_auto = 1'b0; man_ready = 1'b0; man_rdata = 32'h11112222;
      m1_valid = 1'b1; m1_addr = 32'h30; m1_wstrb = 4'h0;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (m1_ready !== 1'b0 || timeout_err !== 1'b0 || s_valid !== 1'b1) early++;
      end
      n_checks++;
      if (early != 0) begin n_fail++; $display("FAIL to_early: got %0d bad cycles expected 0", early); end
      tick();
      n_checks++;
      if (m1_ready !== 1'b1 || m1_rdata !== 32'hDEADBEEF || s_valid !== 1'b0) begin
         n_fail++; $display("FAIL to_fire: got ready=%b rdata=%h s_valid=%b expected 1 deadbeef 0", m1_ready, m1_rdata, s_valid);
      end
      n_checks++;
      if (m0_ready !== 1'b0 || m0_rdata !== 32'h11112222) begin
         n_fail++; $display("FAIL to_other: got m0_ready=%b m0_rdata=%h expected 0 11112222", m0_ready, m0_rdata);
      end
      tick();
      m1_valid = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b1 || dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL to_err_set: got err=%b state=%0d expected 1 0", timeout_err, dbg_state);
      end
      repeat (3) tick();
      n_checks++;
      if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b expected 1", timeout_err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clr: got %b expected 0", timeout_err); end
   endtask

   task automatic test_ready_at_timeout();
      do_reset();
      slave_auto = 1'b0; man_ready = 1'b0;
      m0_valid = 1'b1; m0_addr = 32'h40; m0_wstrb = 4'h0;
      repeat (7) tick();
      tick();
      man_ready = 1'b1; man_rdata = 32'hCAFEF00D;
      #1;
      n_checks++;
      if (m0_ready !== 1'b1 || m0_rdata !== 32'hCAFEF00D || s_valid !== 1'b1) begin
         n_fail++; $display("FAIL race_data: got ready=%b rdata=%h s_valid=%b expected 1 cafef00d 1", m0_ready, m0_rdata, s_valid);
      end
      tick();
      man_ready = 1'b0; m0_valid = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b0 || dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL race_noerr: got err=%b state=%0d expected 0 0", timeout_err, dbg_state);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      slave_auto = 1'b0; man_ready = 1'b0;
      m1_valid = 1'b1; m1_addr = 32'h50;
      tick();
      man_ready = 1'b1;
      #1;
      n_checks++;
      if (s_valid !== 1'b1 || m1_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre: got s_valid=%b m1_ready=%b expected 1 1", s_valid, m1_ready);
      end
      resetn = 1'b0;
      #1;
      n_checks++;
      if (s_valid !== 1'b0 || m1_ready !== 1'b0 || dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL mid_async: got s_valid=%b m1_ready=%b state=%0d expected 0 0 0", s_valid, m1_ready, dbg_state);
      end
      man_ready = 1'b0; slave_auto = 1'b1;
      m0_valid = 1'b1; m0_addr = 32'h10;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      n_checks++;
      if (dbg_state !== S_BUSY0) begin n_fail++; $display("FAIL mid_first_grant: got %0d expected %0d", dbg_state, S_BUSY0); end
      tick();
      tick();
      idle_masters();
      repeat (2) tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_read();
      test_both_write_read();
      test_round_robin();
      test_timeout();
      test_ready_at_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
